// File: rtl/fetch_mux_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_mux_stage_pkg
//   Core-wide constants and types shared by the fetch stage.
//   ADDR_WIDTH      : instruction address width in bits
//   addr_t          : instruction address type
//   PC_RESET_VECTOR : address the PC register takes on reset
// -----------------------------------------------------------------------------
package fetch_mux_stage_pkg;

   localparam int unsigned ADDR_WIDTH = 32;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   localparam addr_t PC_RESET_VECTOR = 32'h0000_0000;

endpackage : fetch_mux_stage_pkg

// File: rtl/fetch_mux_stage_mux2.sv
// -----------------------------------------------------------------------------
// fetch_mux_stage_mux2
//   Parameterised WIDTH-bit 2:1 multiplexer, purely combinational.
//   in0 : selected when sel = 0
//   in1 : selected when sel = 1
//   sel : select
//   out : selected input, bits passed through unchanged
// -----------------------------------------------------------------------------
module fetch_mux_stage_mux2 #(
   parameter int unsigned WIDTH = fetch_mux_stage_pkg::ADDR_WIDTH
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   // NOTE: every path through a combinational block assigns out; a branch
   // that skips the assignment would infer a latch.
   always_comb begin
      if (sel) begin
         out = in1;
      end else begin
         out = in0;
      end
   end

endmodule : fetch_mux_stage_mux2

// File: rtl/fetch_mux_stage.sv
// -----------------------------------------------------------------------------
// fetch_mux_stage
//   Next-PC selector for the fetch stage. Chooses between the sequential
//   PC+4 result and the branch target, drives the instruction-memory address
//   combinationally and captures it into the PC register.
//
//   clk                 : clock, rising edge
//   reset               : synchronous, active-high
//   add_result          : sequential next address (PC+4)
//   branch_result       : branch target address
//   PCSrc               : 1 selects branch_result, 0 selects add_result
//   instruction_address : selected next address (combinational)
//   pc_q                : registered instruction_address
//   branch_taken_q      : registered PCSrc
// -----------------------------------------------------------------------------
module fetch_mux_stage
   import fetch_mux_stage_pkg::*;
#(
   parameter int unsigned      WIDTH        = ADDR_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] add_result,
   input  logic [WIDTH-1:0] branch_result,
   input  logic             PCSrc,
   output logic [WIDTH-1:0] instruction_address,
   output logic [WIDTH-1:0] pc_q,
   output logic             branch_taken_q
);

   // Address selection carries no state: it follows its inputs even while
   // reset is asserted.
   fetch_mux_stage_mux2 #(
      .WIDTH (WIDTH)
   ) u_next_pc_mux (
      .in0 (add_result),
      .in1 (branch_result),
      .sel (PCSrc),
      .out (instruction_address)
   );

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q           <= RESET_VECTOR;
         branch_taken_q <= 1'b0;
      end else begin
         pc_q           <= instruction_address;
         branch_taken_q <= PCSrc;
      end
   end

endmodule : fetch_mux_stage

// File: tb/tb_fetch_mux_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_mux_stage
//   Directed-vector bench for fetch_mux_stage with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fetch_mux_stage;

   localparam int unsigned W  = 32;
   localparam logic [W-1:0] RV = 32'hBFC0_0000;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] add_result;
   logic [W-1:0] branch_result;
   logic         PCSrc;
   logic [W-1:0] instruction_address;
   logic [W-1:0] pc_q;
   logic         branch_taken_q;

   int n_vec = 0;
   int n_bad = 0;

   fetch_mux_stage #(
      .WIDTH        (W),
      .RESET_VECTOR (RV)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .add_result          (add_result),
      .branch_result       (branch_result),
      .PCSrc               (PCSrc),
      .instruction_address (instruction_address),
      .pc_q                (pc_q),
      .branch_taken_q      (branch_taken_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [W-1:0] add;
      logic [W-1:0] br;
      logic         sel;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{add: 32'h0000_1004, br: 32'h0000_2000, sel: 1'b0, exp: 32'h0000_1004};
      vecs[1] = '{add: 32'h0000_1008, br: 32'hDEAD_BEE0, sel: 1'b1, exp: 32'hDEAD_BEE0};
      vecs[2] = '{add: 32'h5555_AAAA, br: 32'hAAAA_5555, sel: 1'b0, exp: 32'h5555_AAAA};
      vecs[3] = '{add: 32'h5555_AAAA, br: 32'hAAAA_5555, sel: 1'b1, exp: 32'hAAAA_5555};

      // Combinational selection, reset held so registers are quiescent.
      reset = 1'b1; add_result = '0; branch_result = '0; PCSrc = 1'b0;
      @(negedge clk);
      check("all_zero", instruction_address, 32'h0);
      branch_result = 32'h1;
      #1 check("unsel_branch_ignored", instruction_address, 32'h0);
      PCSrc = 1'b1; add_result = 32'h2;
      #1 check("sel_branch", instruction_address, 32'h1);
      PCSrc = 1'b0;
      #1 check("sel_back_to_add", instruction_address, 32'h2);

      // Reset loads the vector; mux keeps following inputs.
      tick();
      check("reset_pc", pc_q, RV);
      check("reset_taken", {31'b0, branch_taken_q}, 32'h0);
      check("reset_ia_follows", instruction_address, 32'h2);

      // Release reset: first edge loads the current mux result.
      reset = 1'b0; PCSrc = 1'b1; branch_result = 32'h0000_0040;
      #1 check("release_ia", instruction_address, 32'h40);
      tick();
      check("release_pc", pc_q, 32'h40);
      check("release_taken", {31'b0, branch_taken_q}, 32'h1);

      // Reset mid-operation only acts at the edge.
      reset = 1'b1; PCSrc = 1'b0; add_result = 32'h0000_0100;
      #1 check("midreset_hold_pc", pc_q, 32'h40);
      check("midreset_hold_taken", {31'b0, branch_taken_q}, 32'h1);
      tick();
      check("midreset_pc", pc_q, RV);
      check("midreset_taken", {31'b0, branch_taken_q}, 32'h0);
      reset = 1'b0;
      tick();
      check("midreset_release_pc", pc_q, 32'h100);

      // Full-width values pass unchanged.
      add_result = 32'hFFFF_FFFC; branch_result = 32'h8000_0000; PCSrc = 1'b0;
      #1 check("width_add_ia", instruction_address, 32'hFFFF_FFFC);
      tick();
      check("width_add_pc", pc_q, 32'hFFFF_FFFC);
      check("width_add_taken", {31'b0, branch_taken_q}, 32'h0);
      PCSrc = 1'b1;
      #1 check("width_br_ia", instruction_address, 32'h8000_0000);
      add_result = 32'h1234_5678;
      #1 check("width_unsel_change", instruction_address, 32'h8000_0000);
      tick();
      check("width_br_pc", pc_q, 32'h8000_0000);
      check("width_br_taken", {31'b0, branch_taken_q}, 32'h1);

      // Select and addresses changing together each cycle.
      for (int i = 0; i < 4; i++) begin
         add_result = vecs[i].add; branch_result = vecs[i].br; PCSrc = vecs[i].sel;
         #1 check($sformatf("vec%0d_ia", i), instruction_address, vecs[i].exp);
         tick();
         check($sformatf("vec%0d_pc", i), pc_q, vecs[i].exp);
         check($sformatf("vec%0d_taken", i), {31'b0, branch_taken_q}, {31'b0, vecs[i].sel});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_fetch_mux_stage

// File: doc/fetch_mux_stage.md
# fetch_mux_stage

Next-PC selector for the fetch stage of the pipelined MIPS core (module name: `fetch_mux`). It chooses between the sequential PC+4 adder result and the branch-target adder result under control of `PCSrc`. The chosen address drives the instruction-memory address combinationally. It is also captured in a PC register for the next fetch. The block sits between the fetch adders / EX-stage branch logic and the PC / instruction memory.

## Interface
Parameters:
- `WIDTH`, default 32: address width in bits.
- `RESET_VECTOR`, default 32'h0000_0000: value loaded into the PC register on reset.

Ports:
- `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `add_result`, input, WIDTH bits: sequential next address (PC+4).
- `branch_result`, input, WIDTH bits: branch target address.
- `PCSrc`, input, 1 bit: 1 selects `branch_result`, 0 selects `add_result`.
- `instruction_address`, output, WIDTH bits: selected next address, combinational.
- `pc_q`, output, WIDTH bits: registered copy of `instruction_address`.
- `branch_taken_q`, output, 1 bit: registered copy of `PCSrc`.

## Operation
- `instruction_address = PCSrc ? branch_result : add_result`.
  - Pure combinational path; it depends on no state, `clk` or `reset`.
- Each rising `clk` with `reset`=0:
  - `pc_q` <= `instruction_address`.
  - `branch_taken_q` <= `PCSrc`.
- Each rising `clk` with `reset`=1:
  - `pc_q` <= `RESET_VECTOR`.
  - `branch_taken_q` <= 0.
  - `instruction_address` still follows its inputs.
- Width rules:
  - All address paths are exactly WIDTH bits.
  - No arithmetic, no extension, no truncation.
  - Bits pass through unchanged.
- Inputs are never altered or masked. A `PCSrc` value of X/Z is not required to resolve to either input.

## Timing
- `instruction_address`: zero-cycle latency. It settles in the same delta after any input change, including when only the unselected input changes (output stays stable) or when the select toggles.
- `pc_q` and `branch_taken_q`: one-cycle latency from inputs to outputs.
- Reset values:
  - `pc_q` = `RESET_VECTOR`.
  - `branch_taken_q` = 0.
  - `instruction_address` has no reset value; it is always the mux result.
- Reset asserted mid-operation: it takes effect at the next rising edge only; registered outputs hold their values until that edge.
- Reset deasserted: the first edge with `reset`=0 loads the current mux result.
- `PCSrc` and an address input changing in the same cycle: the register captures the values present at the edge.

## Structure
- Shared core package holds:
  - `ADDR_WIDTH` (32).
  - `PC_RESET_VECTOR`.
  - `addr_t` typedef.
- The fetch stage reuses these constants.
- One sub-module is natural: `mux2`, a parameterised WIDTH-bit 2:1 mux. `fetch_mux` instantiates it and adds the two registers.

## Test plan
- All inputs 0, `PCSrc`=0 -> `instruction_address`=0.
- `branch_result`=1, `add_result`=0, `PCSrc`=0 -> `instruction_address`=0 (unselected input ignored).
- `PCSrc`=1, `add_result`=2, `branch_result`=1 -> `instruction_address`=1.
- `PCSrc` returns to 0 with `add_result`=2 -> `instruction_address`=2, with no clock needed.
- `reset`=1 for one edge -> `pc_q`=`RESET_VECTOR`, `branch_taken_q`=0.
  - Release reset with `PCSrc`=1, `branch_result`=32'h0000_0040 -> after the next edge `pc_q`=32'h0000_0040, `branch_taken_q`=1.
- Width check: `add_result`=32'hFFFF_FFFC, `branch_result`=32'h8000_0000; toggle `PCSrc` 0/1 -> output exactly matches the selected input.
  - After an edge, `pc_q` also equals the selected value.
